// File: rtl/csa_job_host.sv
// csa_job_host: register front-end that bursts staged job descriptors into the CSA input FIFO
// and captures result records from the CSA output FIFO. Optional irq output: CSA_JOB_HOST_IRQ_EN.

module csa_job_host #(
   parameter int AXI_DATA_WIDTH    = 32,
   parameter int OPT_MEM_ADDR_BITS = 10,
   parameter int JOB_WORDS         = 5,
   parameter int RESULT_WORDS      = 7
) (
   input  logic                         axi_mm_clk,
   input  logic                         rst_n,
   input  logic                         wen,
   input  logic [AXI_DATA_WIDTH/8-1:0]  wstrb,
   input  logic [OPT_MEM_ADDR_BITS-1:0] waddr,
   input  logic [AXI_DATA_WIDTH-1:0]    wdata,
   input  logic                         ren,
   input  logic [OPT_MEM_ADDR_BITS-1:0] raddr,
   output logic [AXI_DATA_WIDTH-1:0]    rdata,
   input  logic                         csa_in_w_ready,
   output logic                         csa_in_wen,
   output logic [AXI_DATA_WIDTH-1:0]    csa_in_wdata,
   input  logic                         csa_out_r_ready,
   output logic                         csa_out_ren,
   input  logic [AXI_DATA_WIDTH-1:0]    csa_out_rdata
`ifdef CSA_JOB_HOST_IRQ_EN
   ,
   output logic                         irq
`endif
);

   localparam int AW = OPT_MEM_ADDR_BITS;
   localparam int DW = AXI_DATA_WIDTH;
   localparam int KW = (JOB_WORDS > 1) ? $clog2(JOB_WORDS) : 1;
   localparam int JW = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;

   localparam logic [AW-1:0] A_CTRL = AW'(0);
   localparam logic [AW-1:0] A_JOB0 = AW'(1);
   localparam logic [AW-1:0] A_RV   = AW'(JOB_WORDS + 1);
   localparam logic [AW-1:0] A_RES0 = AW'(JOB_WORDS + 2);
   localparam logic [AW-1:0] A_JCNT = AW'(JOB_WORDS + RESULT_WORDS + 2);
   localparam logic [AW-1:0] A_RCNT = AW'(JOB_WORDS + RESULT_WORDS + 3);
   localparam logic [KW-1:0] K_LAST = KW'(JOB_WORDS - 1);
   localparam logic [JW-1:0] J_LAST = JW'(RESULT_WORDS - 1);

   localparam logic [1:0] T_IDLE  = 2'd0;
   localparam logic [1:0] T_WAIT  = 2'd1;
   localparam logic [1:0] T_PUSH  = 2'd2;
   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_READ  = 2'd1;
   localparam logic [1:0] R_DRAIN = 2'd2;

   function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0]   old_v,
                                                input logic [DW-1:0]   new_v,
                                                input logic [DW/8-1:0] strb);
      logic [DW-1:0] res;
      res = old_v;
      for (int b = 0; b < DW/8; b++) begin
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
         else         res[8*b +: 8] = old_v[8*b +: 8];
      end
      return res;
   endfunction

   logic [1:0]    tx_state_r;
   logic [1:0]    rx_state_r;
   logic [KW-1:0] k_r;
   logic [JW-1:0] rd_cnt_r;
   logic [JW-1:0] cap_idx_r;
   logic          tx_busy_r;
   logic          overrun_r;
   logic          result_valid_r;
   logic          ren_d_r;
   logic [DW-1:0] job_r    [JOB_WORDS];
   logic [DW-1:0] result_r [RESULT_WORDS];
   logic [31:0]   job_cnt_r;
   logic [31:0]   result_cnt_r;

   logic          irq_en_s;
   logic          wr_ctrl_s;
   logic          commit_s;
   logic          wr_job_s;
   logic          ack_s;
   logic          clr_cnt_s;
   logic          job_done_s;
   logic          rx_done_s;
   logic [KW-1:0] job_widx_s;
   logic [KW-1:0] job_ridx_s;
   logic [JW-1:0] res_ridx_s;
   logic [DW-1:0] rd_val_s;

   // Write-side decode and FSM completion events
   always_comb begin
      wr_ctrl_s  = wen && (waddr == A_CTRL) && wstrb[0];
      commit_s   = wr_ctrl_s && wdata[0];
      wr_job_s   = wen && (waddr >= A_JOB0) && (waddr < A_RV) && !tx_busy_r;
      job_widx_s = KW'(waddr - A_JOB0);
      ack_s      = wen && (waddr == A_RV);
      clr_cnt_s  = wen && (waddr == A_JCNT);
      job_done_s = (tx_state_r == T_PUSH) && (k_r == K_LAST);
      rx_done_s  = (rx_state_r == R_DRAIN);
   end

   // Read mux; unmapped addresses return a tagged echo of the address
   always_comb begin
      rd_val_s   = '0;
      job_ridx_s = KW'(raddr - A_JOB0);
      res_ridx_s = JW'(raddr - A_RES0);
      if (raddr == A_CTRL) begin
         rd_val_s[0] = tx_busy_r;
         rd_val_s[1] = irq_en_s;
         rd_val_s[2] = overrun_r;
         rd_val_s[3] = result_valid_r;
      end else if ((raddr >= A_JOB0) && (raddr < A_RV)) begin
         rd_val_s = job_r[job_ridx_s];
      end else if (raddr == A_RV) begin
         rd_val_s[0] = result_valid_r;
      end else if ((raddr >= A_RES0) && (raddr < A_JCNT)) begin
         rd_val_s = result_r[res_ridx_s];
      end else if (raddr == A_JCNT) begin
         rd_val_s = DW'(job_cnt_r);
      end else if (raddr == A_RCNT) begin
         rd_val_s = DW'(result_cnt_r);
      end else begin
         rd_val_s[AW-1:0]    = raddr;
         rd_val_s[DW-1 -: 16] = 16'hE000;
      end
   end

   // Status flags, counters, job staging and registered read data
   always_ff @(posedge axi_mm_clk) begin
      if (!rst_n) begin
         overrun_r      <= 1'b0;
         result_valid_r <= 1'b0;
         job_cnt_r      <= 32'd0;
         result_cnt_r   <= 32'd0;
         rdata          <= '0;
         for (int i = 0; i < JOB_WORDS; i++) job_r[i] <= '0;
      end else begin
         if (commit_s && tx_busy_r)          overrun_r <= 1'b1;
         else if (wr_ctrl_s && wdata[2])     overrun_r <= 1'b0;
         // a record landing in the same cycle as an ack stays valid
         if (rx_done_s)                      result_valid_r <= 1'b1;
         else if (ack_s)                     result_valid_r <= 1'b0;
         if (clr_cnt_s)                      job_cnt_r <= 32'd0;
         else if (job_done_s)                job_cnt_r <= job_cnt_r + 32'd1;
         if (clr_cnt_s)                      result_cnt_r <= 32'd0;
         else if (rx_done_s)                 result_cnt_r <= result_cnt_r + 32'd1;
         if (wr_job_s) job_r[job_widx_s] <= apply_strb(job_r[job_widx_s], wdata, wstrb);
         if (ren)      rdata <= rd_val_s;
      end
   end

   // TX: wait for room, then push the whole descriptor without re-checking ready
   always_ff @(posedge axi_mm_clk) begin
      if (!rst_n) begin
         tx_state_r   <= T_IDLE;
         tx_busy_r    <= 1'b0;
         k_r          <= '0;
         csa_in_wen   <= 1'b0;
         csa_in_wdata <= '0;
      end else begin
         case (tx_state_r)
            T_IDLE: begin
               if (commit_s) begin
                  tx_busy_r  <= 1'b1;
                  tx_state_r <= T_WAIT;
               end
            end
            T_WAIT: begin
               if (csa_in_w_ready) begin
                  tx_state_r   <= T_PUSH;
                  k_r          <= '0;
                  csa_in_wen   <= 1'b1;
                  csa_in_wdata <= job_r[0];
               end
            end
            T_PUSH: begin
               if (k_r == K_LAST) begin
                  csa_in_wen <= 1'b0;
                  tx_busy_r  <= 1'b0;
                  tx_state_r <= T_IDLE;
               end else begin
                  k_r          <= k_r + KW'(1);
                  csa_in_wdata <= job_r[k_r + KW'(1)];
               end
            end
            default: begin
               tx_state_r <= T_IDLE;
               tx_busy_r  <= 1'b0;
               csa_in_wen <= 1'b0;
            end
         endcase
      end
   end

   // RX: issue one read per result word once software has released the previous record
   always_ff @(posedge axi_mm_clk) begin
      if (!rst_n) begin
         rx_state_r  <= R_IDLE;
         rd_cnt_r    <= '0;
         csa_out_ren <= 1'b0;
      end else begin
         case (rx_state_r)
            R_IDLE: begin
               if (!result_valid_r && csa_out_r_ready) begin
                  rx_state_r  <= R_READ;
                  rd_cnt_r    <= '0;
                  csa_out_ren <= 1'b1;
               end
            end
            R_READ: begin
               if (rd_cnt_r == J_LAST) begin
                  csa_out_ren <= 1'b0;
                  rx_state_r  <= R_DRAIN;
               end else begin
                  rd_cnt_r <= rd_cnt_r + JW'(1);
               end
            end
            R_DRAIN: rx_state_r <= R_IDLE;
            default: begin
               rx_state_r  <= R_IDLE;
               csa_out_ren <= 1'b0;
            end
         endcase
      end
   end

   // Result capture trails each FIFO read by one cycle
   always_ff @(posedge axi_mm_clk) begin
      if (!rst_n) begin
         ren_d_r   <= 1'b0;
         cap_idx_r <= '0;
         for (int j = 0; j < RESULT_WORDS; j++) result_r[j] <= '0;
      end else begin
         ren_d_r <= csa_out_ren;
         if (ren_d_r) begin
            result_r[cap_idx_r] <= csa_out_rdata;
            cap_idx_r           <= (cap_idx_r == J_LAST) ? '0 : cap_idx_r + JW'(1);
         end
      end
   end

`ifdef CSA_JOB_HOST_IRQ_EN
   logic irq_en_r;

   // Interrupt enable and registered interrupt output
   always_ff @(posedge axi_mm_clk) begin
      if (!rst_n) begin
         irq_en_r <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (wr_ctrl_s) irq_en_r <= wdata[1];
         irq <= result_valid_r & irq_en_r;
      end
   end

   assign irq_en_s = irq_en_r;
`else
   assign irq_en_s = 1'b0;
`endif

endmodule

// File: tb/tb_csa_job_host.sv
// Testbench for csa_job_host: directed sequence with randomized data against a behavioural model.
// Works with and without CSA_JOB_HOST_IRQ_EN.

module tb_csa_job_host;

`ifdef CSA_JOB_HOST_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wen;
   logic [3:0]  wstrb;
   logic [9:0]  waddr;
   logic [31:0] wdata;
   logic        ren;
   logic [9:0]  raddr;
   logic [31:0] rdata;
   logic        in_ready;
   logic        csa_in_wen;
   logic [31:0] csa_in_wdata;
   logic        csa_out_r_ready;
   logic        csa_out_ren;
   logic [31:0] csa_out_rdata = 32'd0;
`ifdef CSA_JOB_HOST_IRQ_EN
   logic        irq;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   csa_job_host dut (
      .axi_mm_clk      (clk),
      .rst_n           (rst_n),
      .wen             (wen),
      .wstrb           (wstrb),
      .waddr           (waddr),
      .wdata           (wdata),
      .ren             (ren),
      .raddr           (raddr),
      .rdata           (rdata),
      .csa_in_w_ready  (in_ready),
      .csa_in_wen      (csa_in_wen),
      .csa_in_wdata    (csa_in_wdata),
      .csa_out_r_ready (csa_out_r_ready),
      .csa_out_ren     (csa_out_ren),
      .csa_out_rdata   (csa_out_rdata)
`ifdef CSA_JOB_HOST_IRQ_EN
      ,
      .irq             (irq)
`endif
   );

   // Output FIFO model: data one cycle after ren; ready when a whole record is stored
   logic [31:0] fifo_mem [0:63];
   int          fifo_wp = 0;
   int          fifo_rp = 0;
   logic        out_en  = 1'b0;
   assign csa_out_r_ready = out_en && ((fifo_wp - fifo_rp) >= 7);
   always @(posedge clk) begin
      if (csa_out_ren) begin
         csa_out_rdata <= fifo_mem[fifo_rp % 64];
         fifo_rp       <= fifo_rp + 1;
      end
   end

   // Record every push and every FIFO read with its cycle number
   logic [31:0] push_d [$];
   int          push_c [$];
   int          ren_c  [$];
   always @(negedge clk) begin
      if (csa_in_wen) begin
         push_d.push_back(csa_in_wdata);
         push_c.push_back(cyc);
      end
      if (csa_out_ren) ren_c.push_back(cyc);
   end

   // Reference state
   logic [31:0] job_m [5];
   logic [31:0] res_m [7];
   bit          ov_m, rv_m, ie_m, busy_m;
   int unsigned jc_m, rc_m;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] m;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~m) | (n & m);
   endfunction

   function automatic logic [31:0] ctrl_exp();
      return {28'd0, rv_m, ov_m, ie_m & IRQ, busy_m};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 5; i++) job_m[i] = 32'd0;
      for (int j = 0; j < 7; j++) res_m[j] = 32'd0;
      ov_m = 1'b0; rv_m = 1'b0; ie_m = 1'b0; busy_m = 1'b0;
      jc_m = 0; rc_m = 0;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
      waddr = a; wdata = d; wstrb = s; wen = 1'b1;
      tick(1);
      wen = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [9:0] a, input logic [31:0] e);
      raddr = a; ren = 1'b1;
      tick(1);
      ren = 1'b0;
      chk(tag, rdata, e);
   endtask

   task automatic check_all_regs(input string tag);
      rdchk({tag, "_ctrl"}, 10'd0, ctrl_exp());
      for (int i = 0; i < 5; i++) rdchk({tag, "_job"}, 10'(1 + i), job_m[i]);
      rdchk({tag, "_rv"}, 10'd6, {31'd0, rv_m});
      for (int j = 0; j < 7; j++) rdchk({tag, "_res"}, 10'(7 + j), res_m[j]);
      rdchk({tag, "_jcnt"}, 10'd14, jc_m);
      rdchk({tag, "_rcnt"}, 10'd15, rc_m);
   endtask

   initial begin
      int t, r, a, p0, r0;
      logic [31:0] d;
      logic [3:0]  s;
      logic [9:0]  ra;

      rst_n = 1'b0; wen = 1'b0; wstrb = 4'h0; waddr = 10'd0; wdata = 32'd0;
      ren = 1'b0; raddr = 10'd0; in_ready = 1'b0;
      model_reset();
      tick(3);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_in_wen", {31'd0, csa_in_wen}, 32'd0);
      chk("rst_in_wdata", csa_in_wdata, 32'd0);
      chk("rst_out_ren", {31'd0, csa_out_ren}, 32'd0);
`ifdef CSA_JOB_HOST_IRQ_EN
      chk("rst_irq", {31'd0, irq}, 32'd0);
`endif
      rst_n = 1'b1;
      tick(1);
      check_all_regs("reset");

      // Random data under random byte strobes
      for (int i = 0; i < 5; i++) begin
         d = $urandom; s = 4'($urandom_range(0, 15));
         wr(10'(1 + i), d, s);
         job_m[i] = merge(job_m[i], d, s);
      end
      for (int i = 0; i < 5; i++) rdchk("job_strb", 10'(1 + i), job_m[i]);

      // Known descriptor, commit with room available; a second commit lands as busy clears
      for (int i = 0; i < 5; i++) begin
         d = 32'h11 * (i + 1);
         wr(10'(1 + i), d, 4'hF);
         job_m[i] = d;
      end
      in_ready = 1'b1;
      p0 = push_d.size();
      t = cyc;
      wr(10'd0, 32'h1, 4'hF);
      tick(5);
      wr(10'd0, 32'h1, 4'hF);
      tick(3);
      jc_m++; ov_m = 1'b1;
      chk("burst1_len", push_d.size() - p0, 32'd5);
      for (int i = 0; i < 5 && p0 + i < push_d.size(); i++) begin
         chk("burst1_data", push_d[p0 + i], job_m[i]);
         chk("burst1_cyc", push_c[p0 + i], t + 2 + i);
      end
      rdchk("ctrl_late_commit", 10'd0, ctrl_exp());
      rdchk("jcnt_1", 10'd14, jc_m);
      wr(10'd0, 32'h4, 4'hF);
      ov_m = 1'b0;
      rdchk("ctrl_ovr_clr", 10'd0, ctrl_exp());

      // Commit while the input FIFO has no room
      in_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d = $urandom;
         wr(10'(1 + i), d, 4'hF);
         job_m[i] = d;
      end
      p0 = push_d.size();
      wr(10'd0, 32'h1, 4'hF);
      busy_m = 1'b1;
      tick(20);
      chk("wait_no_push", push_d.size() - p0, 32'd0);
      wr(10'd0, 32'h1, 4'hF);
      ov_m = 1'b1;
      wr(10'd3, $urandom, 4'hF);
      rdchk("ctrl_busy_ovr", 10'd0, ctrl_exp());
      rdchk("job2_locked", 10'd3, job_m[2]);
      in_ready = 1'b1;
      r = cyc;
      tick(8);
      busy_m = 1'b0; jc_m++;
      chk("burst2_len", push_d.size() - p0, 32'd5);
      for (int i = 0; i < 5 && p0 + i < push_d.size(); i++) begin
         chk("burst2_data", push_d[p0 + i], job_m[i]);
         chk("burst2_cyc", push_c[p0 + i], r + 1 + i);
      end
      wr(10'd0, 32'h4, 4'hF);
      ov_m = 1'b0;
      rdchk("ctrl_after_b2", 10'd0, ctrl_exp());
      rdchk("jcnt_2", 10'd14, jc_m);

      // Interrupt enable, then the first result record
      wr(10'd0, 32'h2, 4'hF);
      ie_m = IRQ;
      rdchk("ctrl_irq_en", 10'd0, ctrl_exp());
      for (int j = 0; j < 7; j++) begin
         fifo_mem[fifo_wp % 64] = 32'hA0 + j;
         fifo_wp++;
      end
      r0 = ren_c.size();
      t = cyc;
      out_en = 1'b1;
      tick(8);
      rdchk("rv_t8", 10'd6, 32'd0);
`ifdef CSA_JOB_HOST_IRQ_EN
      chk("irq_t9", {31'd0, irq}, 32'd0);
`endif
      rv_m = 1'b1; rc_m++;
      for (int j = 0; j < 7; j++) res_m[j] = 32'hA0 + j;
      rdchk("rv_t9", 10'd6, 32'd1);
`ifdef CSA_JOB_HOST_IRQ_EN
      chk("irq_t10", {31'd0, irq}, 32'd1);
`endif
      chk("rx1_len", ren_c.size() - r0, 32'd7);
      for (int j = 0; j < 7 && r0 + j < ren_c.size(); j++) chk("rx1_cyc", ren_c[r0 + j], t + 1 + j);
      for (int j = 0; j < 7; j++) rdchk("res1", 10'(7 + j), res_m[j]);

      // Second record waits for the ack; a re-ack as it lands must not clear it
      for (int j = 0; j < 7; j++) begin
         fifo_mem[fifo_wp % 64] = $urandom;
         fifo_wp++;
      end
      r0 = ren_c.size();
      tick(20);
      chk("rx_held", ren_c.size() - r0, 32'd0);
      rdchk("rv_held", 10'd6, 32'd1);
      a = cyc;
      wr(10'd6, $urandom, 4'hF);
`ifdef CSA_JOB_HOST_IRQ_EN
      chk("irq_ack_a1", {31'd0, irq}, 32'd1);
`endif
      tick(1);
`ifdef CSA_JOB_HOST_IRQ_EN
      chk("irq_ack_a2", {31'd0, irq}, 32'd0);
`endif
      tick(7);
      wr(10'd6, $urandom, 4'hF);
      for (int j = 0; j < 7; j++) res_m[j] = fifo_mem[(fifo_wp - 7 + j) % 64];
      rc_m++;
      rdchk("rv_set_wins", 10'd6, 32'd1);
`ifdef CSA_JOB_HOST_IRQ_EN
      chk("irq_rec2", {31'd0, irq}, 32'd1);
`endif
      chk("rx2_len", ren_c.size() - r0, 32'd7);
      for (int j = 0; j < 7 && r0 + j < ren_c.size(); j++) chk("rx2_cyc", ren_c[r0 + j], a + 2 + j);
      for (int j = 0; j < 7; j++) rdchk("res2", 10'(7 + j), res_m[j]);
      rdchk("rcnt_2", 10'd15, rc_m);
      wr(10'd6, 32'd0, 4'hF);
      rv_m = 1'b0;
      tick(1);
      rdchk("ctrl_acked", 10'd0, ctrl_exp());
      out_en = 1'b0;

      // Unmapped addresses and read-data hold
      rdchk("unmapped_3ff", 10'h3FF, 32'hE00003FF);
      for (int n = 0; n < 2; n++) begin
         ra = 10'($urandom_range(16, 1023));
         rdchk("unmapped_rand", ra, {16'hE000, 6'd0, ra});
      end
      raddr = 10'd0;
      tick(2);
      chk("rdata_hold", rdata, {16'hE000, 6'd0, ra});

      // Counter clear
      wr(10'd14, $urandom, 4'hF);
      jc_m = 0; rc_m = 0;
      rdchk("jcnt_clr", 10'd14, jc_m);
      rdchk("rcnt_clr", 10'd15, rc_m);

      // Reset in the middle of a burst (third pushed word)
      in_ready = 1'b1;
      p0 = push_d.size();
      wr(10'd0, 32'h1, 4'hF);
      tick(3);
      rst_n = 1'b0;
      tick(1);
      chk("rst_mid_wen", {31'd0, csa_in_wen}, 32'd0);
      chk("rst_mid_wdata", csa_in_wdata, 32'd0);
      chk("rst_mid_len", push_d.size() - p0, 32'd3);
      tick(1);
      rst_n = 1'b1;
      model_reset();
      tick(1);
      check_all_regs("post_rst");
      chk("post_rst_quiet", push_d.size() - p0, 32'd3);

      // TX is usable again after the abort
      p0 = push_d.size();
      wr(10'd0, 32'h1, 4'hF);
      tick(8);
      jc_m++;
      chk("post_rst_burst", push_d.size() - p0, 32'd5);
      rdchk("post_rst_jcnt", 10'd14, jc_m);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
